// File: rtl/uart_pkg.sv
// uart_pkg: ASCII constants and FSM state encodings shared by uart_hex_tx.
// Optional "0x" prefix states are compiled only when UART_HEX_PREFIX_EN is defined.
`default_nettype none

package uart_pkg;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_X  = 8'h78;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DIGIT = 3'd1;
  localparam logic [2:0] ST_CR    = 3'd2;
  localparam logic [2:0] ST_LF    = 3'd3;
  localparam logic [2:0] ST_PRE0  = 3'd4;
  localparam logic [2:0] ST_PRE1  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_DIGIT = ST_DIGIT,
    S_CR    = ST_CR,
`ifdef UART_HEX_PREFIX_EN
    S_LF    = ST_LF,
    S_PRE0  = ST_PRE0,
    S_PRE1  = ST_PRE1
`else
    S_LF    = ST_LF
`endif
  } state_e;

endpackage

`default_nettype wire

// File: rtl/uart_hex_tx_hex2ascii.sv
// hex2ascii: combinational 4-bit nibble to uppercase ASCII hex digit.
// Revision: 1.0
`default_nettype none

module hex2ascii (
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  // 'A' - 10 = 8'h37, so A..F land on 8'h41..8'h46.
  always_comb begin
    if (nib_i < 4'd10) begin
      asc_o = 8'h30 + {4'h0, nib_i};
    end else begin
      asc_o = 8'h37 + {4'h0, nib_i};
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_hex_tx.sv
// uart_hex_tx: prints a latched binary value as NIB uppercase hex digits + CR LF
// into a uart transmit FIFO. Define UART_HEX_PREFIX_EN to prepend "0x".
`default_nettype none

module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4*NIB-1:0] din,
  input  logic             tx_full,
  output logic             wr_uart,
  output logic [7:0]       w_data,
  output logic             busy,
  output logic             done_tick
);

  localparam int            W    = 4 * NIB;
  localparam int            CW   = $clog2(NIB + 1);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

`ifdef UART_HEX_PREFIX_EN
  localparam state_e FIRST = S_PRE0;
`else
  localparam state_e FIRST = S_DIGIT;
`endif

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic           done_q,  done_d;
  logic [7:0]     digit_asc;

  hex2ascii u_hex2ascii (
    .nib_i (shreg_q[W-1 -: 4]),
    .asc_o (digit_asc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Every non-IDLE state presents one byte; it is consumed only on an edge
  // where the FIFO has room, so all state simply holds while tx_full is high.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_uart = 1'b0;
    w_data  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = FIRST;
        end
      end
`ifdef UART_HEX_PREFIX_EN
      S_PRE0: begin
        w_data  = ASC_0;
        wr_uart = ~tx_full;
        if (!tx_full) state_d = S_PRE1;
      end
      S_PRE1: begin
        w_data  = ASC_X;
        wr_uart = ~tx_full;
        if (!tx_full) state_d = S_DIGIT;
      end
`endif
      S_DIGIT: begin
        w_data  = digit_asc;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          shreg_d = shreg_q << 4;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_CR;
        end
      end
      S_CR: begin
        w_data  = ASC_CR;
        wr_uart = ~tx_full;
        if (!tx_full) state_d = S_LF;
      end
      S_LF: begin
        w_data  = ASC_LF;
        wr_uart = ~tx_full;
        if (!tx_full) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done_tick = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_hex_tx.sv
// tb_uart_hex_tx: directed self-checking bench for uart_hex_tx (NIB=4).
// Expected byte streams include the "0x" prefix when UART_HEX_PREFIX_EN is defined.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_hex_tx;

  localparam int NIB = 4;
`ifdef UART_HEX_PREFIX_EN
  localparam int PRE = 2;
`else
  localparam int PRE = 0;
`endif

  typedef logic [7:0] bq_t[$];

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        start   = 1'b0;
  logic        tx_full = 1'b0;
  logic [15:0] din     = 16'h0000;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic        busy;
  logic        done_tick;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] wq[$];
  int         cq[$];

  uart_hex_tx #(.NIB(NIB)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data),
    .busy      (busy),
    .done_tick (done_tick)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  // A byte presented at this negedge is written on the following posedge.
  always @(negedge clk) begin
    if (wr_uart === 1'b1) begin
      wq.push_back(w_data);
      cq.push_back(cyc);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // digs packs the four expected digit bytes, MSB digit first.
  task automatic mk_exp(input logic [31:0] digs, output bq_t q);
    q = {};
`ifdef UART_HEX_PREFIX_EN
    q.push_back(8'h30);
    q.push_back(8'h78);
`endif
    for (int i = 3; i >= 0; i--) q.push_back(digs[8*i +: 8]);
    q.push_back(8'h0D);
    q.push_back(8'h0A);
  endtask

  task automatic start_msg(input logic [15:0] d, output int scyc);
    tick();
    wq.delete();
    cq.delete();
    din   = d;
    start = 1'b1;
    scyc  = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output bit got, output int dcyc);
    got  = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_tick === 1'b1) begin
        got  = 1'b1;
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_uart !== 1'b0 || busy !== 1'b0 || done_tick !== 1'b0 || w_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: wr=%b busy=%b done=%b data=%h, want 0 0 0 00",
               wr_uart, busy, done_tick, w_data);
    end
    tick();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if (wq.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: writes=%0d busy=%b, want 0 0", wq.size(), busy);
    end
  endtask

  task automatic test_patterns;
    logic [15:0] dv [3] = '{16'h1234, 16'hBEEF, 16'h09FA};
    logic [31:0] ev [3] = '{32'h31323334, 32'h42454546, 32'h30394641};
    bq_t exp;
    int sc, dc;
    bit got;
    logic [7:0] g;
    for (int t = 0; t < 3; t++) begin
      mk_exp(ev[t], exp);
      start_msg(dv[t], sc);
      wait_done(got, dc);
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL pat%0d_done: done_tick not seen within 40 cycles", t);
      end
      checks++;
      if (wq.size() != exp.size()) begin
        failures++;
        $display("FAIL pat%0d_count: got %0d bytes, want %0d", t, wq.size(), exp.size());
      end
      for (int i = 0; i < exp.size(); i++) begin
        g = 8'hxx;
        if (i < wq.size()) g = wq[i];
        checks++;
        if (g !== exp[i]) begin
          failures++;
          $display("FAIL pat%0d_byte%0d: got %h, want %h", t, i, g, exp[i]);
        end
      end
      if (cq.size() == exp.size()) begin
        checks++;
        if (cq[0] != sc + 1) begin
          failures++;
          $display("FAIL pat%0d_latency: first write cycle %0d, want %0d", t, cq[0], sc + 1);
        end
        checks++;
        if (cq[cq.size()-1] - cq[0] != exp.size() - 1) begin
          failures++;
          $display("FAIL pat%0d_consecutive: span %0d, want %0d", t,
                   cq[cq.size()-1] - cq[0], exp.size() - 1);
        end
        checks++;
        if (got && dc != cq[cq.size()-1] + 1) begin
          failures++;
          $display("FAIL pat%0d_done_timing: done cycle %0d, want %0d", t, dc, cq[cq.size()-1] + 1);
        end
      end
      @(negedge clk);
      checks++;
      if (done_tick !== 1'b0 || busy !== 1'b0 || wr_uart !== 1'b0) begin
        failures++;
        $display("FAIL pat%0d_after: done=%b busy=%b wr=%b, want 0 0 0", t, done_tick, busy, wr_uart);
      end
    end
  endtask

  task automatic test_stall;
    bq_t exp;
    int sc, dc;
    bit got, ok;
    logic [7:0] g;
    mk_exp(32'h41354333, exp);
    start_msg(16'hA5C3, sc);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wq.size() >= PRE + 2) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL stall_reach: only %0d bytes before stall, want %0d", wq.size(), PRE + 2);
    end
    tx_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (wr_uart !== 1'b0 || w_data !== 8'h43 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d: wr=%b data=%h busy=%b, want 0 43 1", s, wr_uart, w_data, busy);
      end
    end
    tick();
    tx_full = 1'b0;
    checks++;
    if (wq.size() != PRE + 2) begin
      failures++;
      $display("FAIL stall_nowrite: %0d bytes after stall, want %0d", wq.size(), PRE + 2);
    end
    wait_done(got, dc);
    checks++;
    if (!got || wq.size() != exp.size()) begin
      failures++;
      $display("FAIL stall_count: done=%b bytes=%0d, want 1 %0d", got, wq.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      g = 8'hxx;
      if (i < wq.size()) g = wq[i];
      checks++;
      if (g !== exp[i]) begin
        failures++;
        $display("FAIL stall_byte%0d: got %h, want %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    bq_t exp1, exp2;
    int sc, dc;
    bit got;
    logic [7:0] g;
    mk_exp(32'h39433037, exp1);
    mk_exp(32'h30303031, exp2);
    start_msg(16'h9C07, sc);
    tick();
    din   = 16'hFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    din   = 16'h0000;
    wait_done(got, dc);
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL b2b_done1: done_tick not seen within 40 cycles");
    end
    din   = 16'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    din   = 16'h0000;
    checks++;
    if (wq.size() != exp1.size()) begin
      failures++;
      $display("FAIL b2b_count1: got %0d bytes, want %0d", wq.size(), exp1.size());
    end
    for (int i = 0; i < exp1.size(); i++) begin
      g = 8'hxx;
      if (i < wq.size()) g = wq[i];
      checks++;
      if (g !== exp1[i]) begin
        failures++;
        $display("FAIL b2b_msg1_byte%0d: got %h, want %h", i, g, exp1[i]);
      end
    end
    wq.delete();
    cq.delete();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept: busy=%b after start on done_tick cycle, want 1", busy);
    end
    wait_done(got, dc);
    checks++;
    if (!got || wq.size() != exp2.size()) begin
      failures++;
      $display("FAIL b2b_count2: done=%b bytes=%0d, want 1 %0d", got, wq.size(), exp2.size());
    end
    for (int i = 0; i < exp2.size(); i++) begin
      g = 8'hxx;
      if (i < wq.size()) g = wq[i];
      checks++;
      if (g !== exp2[i]) begin
        failures++;
        $display("FAIL b2b_msg2_byte%0d: got %h, want %h", i, g, exp2[i]);
      end
    end
  endtask

  task automatic test_reset_abort;
    int sc;
    bit ok;
    start_msg(16'h1234, sc);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wq.size() >= 3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL abort_reach: only %0d bytes written, want 3", wq.size());
    end
    reset = 1'b0;
    #1;
    checks++;
    if (wr_uart !== 1'b0 || busy !== 1'b0 || done_tick !== 1'b0 || w_data !== 8'h00) begin
      failures++;
      $display("FAIL abort_immediate: wr=%b busy=%b done=%b data=%h, want 0 0 0 00",
               wr_uart, busy, done_tick, w_data);
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (6) tick();
    checks++;
    if (wq.size() != 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet: bytes=%0d busy=%b, want 3 0", wq.size(), busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_patterns();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_hex_tx.md
Name: uart_hex_tx

Overview:
- Message formatter directly upstream of the uart transmit path; drives its wr_uart/w_data write port and honours tx_full.
- On a start pulse, latches a binary value and emits it as fixed-width uppercase ASCII hex, followed by CR LF.
- Used to print register and debug values to a serial terminal at 19200 8N1 without any processor.

Parameters:
- NIB, 4, number of hex digits sent; data width = 4*NIB; legal range 1..8.

Ports:
- clk  input  1  system clock (50 MHz)
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle request to send din; accepted only when busy=0
- din  input  4*NIB  value to print, MSB nibble first
- tx_full  input  1  uart transmit FIFO full flag
- wr_uart  output  1  write strobe to the uart transmit FIFO
- w_data  output  8  ASCII byte to the uart transmit FIFO
- busy  output  1  high from the cycle after start is accepted until the final byte is written
- done_tick  output  1  one-cycle pulse after the LF byte is written

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; shift register, digit counter and done_tick cleared; wr_uart=0, w_data=8'h00, busy=0, done_tick=0.
- FSM states: IDLE, DIGIT, CR, LF. With the macro defined, PRE0 and PRE1 sit between IDLE and DIGIT.
- IDLE:
  - start=1 latches din into the shift register, clears the digit counter, and moves to DIGIT (or PRE0).
  - start=0 remains in IDLE.
- Write rule:
  - wr_uart = (state != IDLE) & ~tx_full; this is combinational from registered state and tx_full.
  - w_data is combinational from state and the top nibble; it is 8'h00 in IDLE.
  - A byte counts as written on a clock edge where wr_uart=1. The state advances only on a write.
  - While tx_full=1, the state, shift register and counter hold, and w_data stays stable.
- DIGIT:
  - w_data = ASCII of shreg[4*NIB-1 -: 4]. 0..9 map to 8'h30..8'h39; A..F map to 8'h41..8'h46 (uppercase).
  - On each write, shift left by 4 and increment the counter. After the write with counter = NIB-1, go to CR.
- CR: w_data = 8'h0D; on write, go to LF.
- LF: w_data = 8'h0A; on write, go to IDLE and set done_tick=1 for exactly the next cycle.
- Throughput and latency:
  - With tx_full=0 throughout, the message takes NIB+2 consecutive write cycles.
  - The first write is in the cycle after start is accepted.
  - done_tick is high in the first IDLE cycle; a start in that same cycle is accepted.
- start while busy=1 is ignored; there is no queueing and din is not re-sampled.
- Reset mid-message aborts immediately: no further bytes are written, and the partial message is left in the FIFO.
- The counter is ceil(log2(NIB+1)) bits wide; no wrap-around is possible within a message.

Optional Feature:
- Macro: UART_HEX_PREFIX_EN.
- Defined: every message starts with "0x". PRE0 sends 8'h30 and PRE1 sends 8'h78, using the same tx_full gating, so a message is NIB+4 bytes.
- Undefined: PRE0 and PRE1 are not compiled, and a message is NIB+2 bytes.

Decomposition:
- Package uart_pkg:
  - ASCII constants: ASC_CR=8'h0D, ASC_LF=8'h0A, ASC_0=8'h30, ASC_X=8'h78.
  - Localparam state encodings for the FSM.
- Sub-module hex2ascii: combinational 4-bit nibble to 8-bit ASCII converter, instantiated once on the top nibble.

Test Plan:
- din=16'h1234, start pulse, tx_full=0 -> w_data 31,32,33,34,0D,0A on 6 consecutive cycles; done_tick one cycle later; busy low afterwards.
- din=16'hBEEF -> bytes 42,45,45,46,0D,0A, confirming uppercase mapping.
- din=16'hA5C3 with tx_full forced high for 3 cycles after the second byte -> no writes during the stall, w_data held at 43, then 43,33,0D,0A; total 6 writes in order.
- Second start pulse 2 cycles into the message with din=16'hFFFF -> ignored; output is exactly the first message; start on the done_tick cycle is accepted.
- reset driven low after the 3rd byte -> wr_uart=0, busy=0, done_tick=0 immediately; no further writes after release until a new start.
- UART_HEX_PREFIX_EN defined, din=16'h00AF -> 30,78,30,30,41,46,0D,0A. Also a loopback through the uart (tx to rx), reading r_data, returns the identical byte sequence.
